// File: rtl/ahb_mux_dphase_if.sv
// Bus bundle for ahb_mux_dphase: address-phase select/valid, HREADY, per-channel
// payloads and the data-phase outputs. The mux attaches through the slave modport.
interface ahb_mux_dphase_if #(
    parameter int unsigned CHANNEL_NUM = 7,
    parameter int unsigned PAYLOAD     = 34,
    parameter int unsigned ERR_CNT_W   = 8
);
    logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] payload_in;
    logic [CHANNEL_NUM-1:0]              sel_a;
    logic                                trans_valid;
    logic                                hready_in;
    logic [PAYLOAD-1:0]                  payload_out;
    logic [CHANNEL_NUM-1:0]              sel_d;
    logic                                dphase_active;
    logic                                sel_err;
    logic [ERR_CNT_W-1:0]                err_cnt;

    modport master (
        output payload_in, sel_a, trans_valid, hready_in,
        input  payload_out, sel_d, dphase_active, sel_err, err_cnt
    );

    modport slave (
        input  payload_in, sel_a, trans_valid, hready_in,
        output payload_out, sel_d, dphase_active, sel_err, err_cnt
    );
endinterface

// File: rtl/ahb_mux_dphase.sv
// AHB data-phase payload mux: registers the address-phase one-hot select on HREADY
// and muxes payload_in from it. Define AHB_MUX_SELERR_EN for multi-hot select error reporting.
module ahb_mux_dphase #(
    parameter int unsigned        CHANNEL_NUM     = 7,
    parameter int unsigned        PAYLOAD         = 34,
    parameter logic [PAYLOAD-1:0] DEFAULT_PAYLOAD = '0,
    parameter int unsigned        ERR_CNT_W       = 8
) (
    input logic             hclk,
    input logic             hreset_n,
    ahb_mux_dphase_if.slave bus
);
    logic [CHANNEL_NUM-1:0] sel_res;
    logic [CHANNEL_NUM-1:0] dsel_q, dsel_d;
    logic                   dact_q, dact_d;
    logic [PAYLOAD-1:0]     payload_mux;

    // x & -x isolates the lowest set bit, giving lowest-index priority on multi-hot selects
    assign sel_res = bus.sel_a & (~bus.sel_a + CHANNEL_NUM'(1));

    always_comb begin
        dsel_d = dsel_q;
        dact_d = dact_q;
        if (bus.hready_in) begin
            dsel_d = bus.trans_valid ? sel_res : '0;
            dact_d = bus.trans_valid && (bus.sel_a != '0);
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            dsel_q <= '0;
            dact_q <= 1'b0;
        end else begin
            dsel_q <= dsel_d;
            dact_q <= dact_d;
        end
    end

    // dsel_q is one-hot or zero, so at most one channel ever matches
    always_comb begin
        payload_mux = DEFAULT_PAYLOAD;
        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            if (dsel_q[i]) payload_mux = bus.payload_in[i];
        end
    end

    assign bus.payload_out   = payload_mux;
    assign bus.sel_d         = dsel_q;
    assign bus.dphase_active = dact_q;

`ifdef AHB_MUX_SELERR_EN
    logic                 multi_hot;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    assign multi_hot = (bus.sel_a & (bus.sel_a - CHANNEL_NUM'(1))) != '0;

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (bus.hready_in && bus.trans_valid && multi_hot) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.sel_err = err_q;
    assign bus.err_cnt = cnt_q;
`else
    assign bus.sel_err = 1'b0;
    assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_ahb_mux_dphase.sv
// Directed bench for ahb_mux_dphase: reset, capture/latency, wait-state hold, back-to-back,
// unmapped/idle, multi-hot resolution, error saturation and asynchronous mid-phase reset.
module tb_ahb_mux_dphase;
    localparam int unsigned CH = 7;
    localparam int unsigned PW = 34;
    localparam int unsigned EW = 8;
`ifdef AHB_MUX_SELERR_EN
    localparam bit SELERR = 1'b1;
`else
    localparam bit SELERR = 1'b0;
`endif

    logic          hclk     = 1'b0;
    logic          hreset_n = 1'b0;
    int unsigned   n_eval   = 0;
    int unsigned   n_fail   = 0;
    logic [PW-1:0] ch_pl [CH];

    ahb_mux_dphase_if #(.CHANNEL_NUM(CH), .PAYLOAD(PW), .ERR_CNT_W(EW)) bus ();

    ahb_mux_dphase #(
        .CHANNEL_NUM    (CH),
        .PAYLOAD        (PW),
        .DEFAULT_PAYLOAD(PW'(0)),
        .ERR_CNT_W      (EW)
    ) dut (
        .hclk    (hclk),
        .hreset_n(hreset_n),
        .bus     (bus.slave)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ch < 0 means no channel selected in data phase
    task automatic check_dp(input string tag, input int ch);
        logic [CH-1:0] exp_sel;
        logic [PW-1:0] exp_pl;
        exp_sel = '0;
        exp_pl  = '0;
        if (ch >= 0) begin
            exp_sel[ch] = 1'b1;
            exp_pl      = ch_pl[ch];
        end
        check({tag, ".sel_d"},   64'(bus.sel_d),         64'(exp_sel));
        check({tag, ".dphase"},  64'(bus.dphase_active), 64'(ch >= 0));
        check({tag, ".payload"}, 64'(bus.payload_out),   64'(exp_pl));
    endtask

    task automatic check_err(input string tag, input logic exp_err, input int unsigned exp_cnt);
        check({tag, ".sel_err"}, 64'(bus.sel_err), 64'(exp_err));
        check({tag, ".err_cnt"}, 64'(bus.err_cnt), 64'(exp_cnt));
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            ch_pl[i] = {2'b10, 32'hC0DE_0000 | 32'(i)};
        end
        ch_pl[2] = 34'h1_2345_6789;
        for (int i = 0; i < CH; i++) bus.payload_in[i] = ch_pl[i];
        bus.hready_in   = 1'b1;
        bus.trans_valid = 1'b1;
        bus.sel_a       = 7'b0000100;

        // Edge while in reset must not capture
        tick();
        check_dp("in_reset", -1);
        check_err("in_reset", 1'b0, 0);
        bus.trans_valid = 1'b0;
        bus.sel_a       = '0;
        #17 hreset_n = 1'b1;
        tick();
        check_dp("reset", -1);
        check_err("reset", 1'b0, 0);

        // Single transfer, one-edge latency
        bus.sel_a       = 7'b0000100;
        bus.trans_valid = 1'b1;
        tick();
        check_dp("single", 2);

        // Wait states: new select ignored, payload tracks channel 2
        bus.hready_in = 1'b0;
        bus.sel_a     = 7'b1000000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_dp("hold", 2);
            ch_pl[2]          = ch_pl[2] ^ PW'(34'h3_0000_0001 << k);
            bus.payload_in[2] = ch_pl[2];
            #1;
            check("hold.track", 64'(bus.payload_out), 64'(ch_pl[2]));
        end
        bus.hready_in = 1'b1;
        tick();
        check_dp("hold_release", 6);

        // Back-to-back transfers
        bus.sel_a = 7'b0000001;
        tick();
        check_dp("b2b0", 0);
        bus.sel_a = 7'b0100000;
        tick();
        check_dp("b2b5", 5);
        bus.sel_a = 7'b0001000;
        tick();
        check_dp("b2b3", 3);
        bus.trans_valid = 1'b0;
        bus.sel_a       = 7'b0000010;
        tick();
        check_dp("idle", -1);

        // Unmapped address
        bus.trans_valid = 1'b1;
        bus.sel_a       = '0;
        tick();
        check_dp("unmapped", -1);
        check_err("unmapped", 1'b0, 0);

        // Multi-hot: lowest index wins
        bus.sel_a = 7'b0101000;
        tick();
        check_dp("multi", 3);
        check_err("multi", SELERR, SELERR ? 1 : 0);

        // Hold edges with multi-hot select are not counted
        bus.hready_in = 1'b0;
        bus.sel_a     = 7'b1100000;
        tick();
        tick();
        check_dp("multi_hold", 3);
        check_err("multi_hold", SELERR, SELERR ? 1 : 0);

        bus.hready_in = 1'b1;
        bus.sel_a     = 7'b0101000;
        for (int k = 2; k <= 300; k++) begin
            tick();
            if (k == 254 || k == 255 || k == 300) begin
                check_err($sformatf("sat%0d", k), SELERR,
                          SELERR ? ((k > 255) ? 255 : k) : 0);
            end
        end
        check_dp("multi_sat", 3);

        // Sticky flag, counter stays saturated on clean transfers
        bus.sel_a = 7'b0000001;
        tick();
        check_dp("sticky", 0);
        check_err("sticky", SELERR, SELERR ? 255 : 0);

        // Asynchronous reset mid data phase
        bus.sel_a = 7'b0000010;
        tick();
        check_dp("pre_rst", 1);
        #2 hreset_n = 1'b0;
        #1;
        check_dp("mid_rst", -1);
        check_err("mid_rst", 1'b0, 0);
        #2 hreset_n = 1'b1;
        tick();
        check_dp("post_rst", 1);
        check_err("post_rst", 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
